// File: rtl/relax_freq_counter_if.sv
// Control/result bundle between the frequency counter and its host logic.
// The master side issues start requests; the slave side (the counter) returns readings.
interface relax_freq_counter_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start_i;
    logic [CNT_W-1:0] count_o;
    logic             valid_o;
    logic             ovf_o;
    logic             busy_o;

    modport master (
        output start_i,
        input  count_o,
        input  valid_o,
        input  ovf_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        output count_o,
        output valid_o,
        output ovf_o,
        output busy_o
    );
endinterface

// File: rtl/relax_freq_counter.sv
// Counts synchronized rising edges of the relaxation-oscillator comparator over a fixed gate
// window of clk cycles. Define RELAX_FREQ_CONT_EN for back-to-back continuous measurement.
//
// state | meaning
// IDLE  | waiting for start_i
// ARM   | clear edge counter and saturation flag, load gate timer
// GATE  | count rises; gate timer runs down to terminal count 0
// LATCH | result visible on count_o/ovf_o with valid_o high
module relax_freq_counter #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                osc_in,
    relax_freq_counter_if.slave bus
);
    localparam int unsigned        GATE_W    = 16;
    localparam logic [GATE_W-1:0]  GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0]  GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q, sync_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              rise;

    // sync_q[0..1] is the two-flop synchronizer, sync_q[2] the edge-detect delay
    always_comb begin
        sync_d = {sync_q[1:0], osc_in};
        rise   = sync_q[1] & ~sync_q[2];
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                gate_d     = GATE_LOAD;
                state_d    = ST_GATE;
            end
            ST_GATE: begin
                if (rise) begin
                    if (edge_cnt_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_ONE;
                    end
                end
                if (gate_q != '0) begin
                    gate_d = gate_q - GATE_ONE;
                end else begin
                    // Publish on entry to LATCH so count_o and valid_o appear together,
                    // including a rise seen in this final gate cycle.
                    count_d = edge_cnt_d;
                    ovf_d   = sat_d;
                    valid_d = 1'b1;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
`ifdef RELAX_FREQ_CONT_EN
                state_d = ST_ARM;
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.count_o = count_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_relax_freq_counter.sv
// Bench for relax_freq_counter: two instances (16-bit/100-cycle gate and 4-bit/200-cycle gate)
// checked every cycle against a window-counting reference, plus directed literal checks.
module tb_relax_freq_counter;
    localparam int G_A = 100;
    localparam int W_A = 16;
    localparam int G_B = 200;
    localparam int W_B = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic osc_in = 1'b0;

    relax_freq_counter_if #(.CNT_W(W_A)) if_a ();
    relax_freq_counter_if #(.CNT_W(W_B)) if_b ();

    relax_freq_counter #(.GATE_CYCLES(G_A), .CNT_W(W_A)) dut_a (
        .clk(clk), .rst(rst), .osc_in(osc_in), .bus(if_a)
    );
    relax_freq_counter #(.GATE_CYCLES(G_B), .CNT_W(W_B)) dut_b (
        .clk(clk), .rst(rst), .osc_in(osc_in), .bus(if_b)
    );

    initial forever #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    bit hist [0:16383];
    int gate_len [2] = '{G_A, G_B};
    int max_cnt  [2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
    bit m_busy   [2] = '{1'b0, 1'b0};
    int m_t      [2] = '{0, 0};
    int e_count  [2] = '{0, 0};
    bit e_ovf    [2] = '{1'b0, 1'b0};
    bit e_valid  [2] = '{1'b0, 1'b0};
    int m_raw;
    bit m_start;

    int p_t0      = 0;
    int p_first   = 0;
    int p_spacing = 1;
    int p_n       = 0;
    int p_hi      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dut_count(input int i);
        return (i == 0) ? 32'(if_a.count_o) : 32'(if_b.count_o);
    endfunction
    function automatic logic [31:0] dut_valid(input int i);
        return (i == 0) ? 32'(if_a.valid_o) : 32'(if_b.valid_o);
    endfunction
    function automatic logic [31:0] dut_ovf(input int i);
        return (i == 0) ? 32'(if_a.ovf_o) : 32'(if_b.ovf_o);
    endfunction
    function automatic logic [31:0] dut_busy(input int i);
        return (i == 0) ? 32'(if_a.busy_o) : 32'(if_b.busy_o);
    endfunction

    // Reference: a result is the number of pin rising edges sampled at edges T..T+G-1,
    // published G+1 edges after start was sampled at edge T.
    initial forever begin
        @(posedge clk);
        cyc++;
        hist[cyc] = rst ? 1'b0 : osc_in;
        for (int i = 0; i < 2; i++) begin
            m_start    = (i == 0) ? if_a.start_i : if_b.start_i;
            e_valid[i] = 1'b0;
            if (rst) begin
                m_busy[i]  = 1'b0;
                e_count[i] = 0;
                e_ovf[i]   = 1'b0;
            end else if (m_busy[i]) begin
                if (cyc == m_t[i] + gate_len[i] + 1) begin
                    m_raw = 0;
                    for (int j = m_t[i]; j < m_t[i] + gate_len[i]; j++) begin
                        if (hist[j] && !hist[j-1]) m_raw++;
                    end
                    e_count[i] = (m_raw > max_cnt[i]) ? max_cnt[i] : m_raw;
                    e_ovf[i]   = (m_raw > max_cnt[i]);
                    e_valid[i] = 1'b1;
                end else if (cyc == m_t[i] + gate_len[i] + 2) begin
`ifdef RELAX_FREQ_CONT_EN
                    m_t[i] = cyc;
`else
                    m_busy[i] = 1'b0;
`endif
                end
            end else if (m_start) begin
                m_busy[i] = 1'b1;
                m_t[i]    = cyc;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("count[%0d]", i), dut_count(i), rst ? 0 : e_count[i]);
            chk($sformatf("valid[%0d]", i), dut_valid(i), rst ? 0 : 32'(e_valid[i]));
            chk($sformatf("ovf[%0d]", i),   dut_ovf(i),   rst ? 0 : 32'(e_ovf[i]));
            chk($sformatf("busy[%0d]", i),  dut_busy(i),  rst ? 0 : 32'(m_busy[i]));
        end
    end

    task automatic step();
        int r;
        r = cyc + 1 - p_t0;
        osc_in = (p_n > 0) && (r >= p_first) && (((r - p_first) / p_spacing) < p_n)
                 && (((r - p_first) % p_spacing) < p_hi);
        @(posedge clk);
        #1;
    endtask

    task automatic set_pattern(input int first, input int spacing, input int n, input int hi);
        p_t0      = cyc + 2;
        p_first   = first;
        p_spacing = spacing;
        p_n       = n;
        p_hi      = hi;
    endtask

    task automatic start_pulse(input int i);
        if (i == 0) if_a.start_i = 1'b1; else if_b.start_i = 1'b1;
        step();
        if_a.start_i = 1'b0;
        if_b.start_i = 1'b0;
    endtask

    task automatic measure(input int i, input int first, input int spacing, input int n,
                           input int hi, input int exp_cnt, input int exp_ovf);
        int t;
        set_pattern(first, spacing, n, hi);
        step();
        start_pulse(i);
        t = cyc;
        while (cyc < t + gate_len[i]) step();
        chk("valid_before_latch", dut_valid(i), 0);
        step();
        chk("valid_at_latch", dut_valid(i), 1);
        chk("count_at_latch", dut_count(i), exp_cnt);
        chk("ovf_at_latch", dut_ovf(i), exp_ovf);
        chk("busy_at_latch", dut_busy(i), 1);
        step();
        chk("valid_after_latch", dut_valid(i), 0);
        chk("busy_after_latch", dut_busy(i), 0);
        chk("count_hold", dut_count(i), exp_cnt);
    endtask

    initial begin
        int t;
        int npulse;
        int at;
        int busy_drop;
        if_a.start_i = 1'b0;
        if_b.start_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) step();
        chk("idle_busy_a", dut_busy(0), 0);
        chk("idle_count_b", dut_count(1), 0);

`ifndef RELAX_FREQ_CONT_EN
        measure(0, 10, 8, 7, 4, 7, 0);
        measure(0, 0, 99, 2, 4, 2, 0);
        measure(0, -1, 101, 2, 4, 0, 0);
        measure(1, 10, 6, 20, 3, 15, 1);
        measure(1, 10, 6, 3, 3, 3, 0);
        measure(1, 10, 6, 15, 3, 15, 0);
        measure(1, 10, 6, 16, 3, 15, 1);

        // second start during GATE must be ignored
        set_pattern(10, 8, 7, 4);
        step();
        start_pulse(0);
        t = cyc;
        npulse = 0;
        at = -1;
        while (cyc < t + 300) begin
            if_a.start_i = (cyc == t + 49);
            step();
            if (if_a.valid_o) begin
                npulse++;
                at = cyc;
            end
        end
        if_a.start_i = 1'b0;
        chk("reject_pulses", 32'(npulse), 1);
        chk("reject_pulse_at", 32'(at - t), 101);
        chk("reject_count", dut_count(0), 7);

        // asynchronous reset in the middle of a gate
        set_pattern(10, 8, 7, 4);
        step();
        start_pulse(0);
        t = cyc;
        while (cyc < t + 59) step();
        chk("pre_rst_count_a", dut_count(0), 7);
        chk("pre_rst_busy_a", dut_busy(0), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count_a", dut_count(0), 0);
        chk("async_rst_busy_a", dut_busy(0), 0);
        chk("async_rst_count_b", dut_count(1), 0);
        chk("async_rst_ovf_b", dut_ovf(1), 0);
        repeat (3) step();
        rst = 1'b0;
        npulse = 0;
        repeat (150) begin
            step();
            if (if_a.valid_o) npulse++;
        end
        chk("post_rst_no_valid", 32'(npulse), 0);
        chk("post_rst_busy_a", dut_busy(0), 0);
        measure(0, 5, 12, 5, 6, 5, 0);
`else
        set_pattern(0, 10, 100000, 5);
        step();
        start_pulse(0);
        t = cyc;
        npulse = 0;
        busy_drop = 0;
        repeat (4 * (G_A + 2) + 20) begin
            step();
            if (!if_a.busy_o) busy_drop++;
            if (if_a.valid_o) begin
                chk("cont_pulse_at", 32'(cyc - t), 32'(101 + npulse * 102));
                chk("cont_count_range", 32'((if_a.count_o == 10) || (if_a.count_o == 11)), 1);
                npulse++;
            end
        end
        chk("cont_pulses", 32'(npulse), 4);
        chk("cont_busy_drop", 32'(busy_drop), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/relax_freq_counter.md
# relax_freq_counter

Digital measurement stage downstream of the relaxation-oscillator analog macro. It samples the oscillator's comparator output, which arrives asynchronously, and counts its rising edges over a fixed gate window of `clk` cycles. At the end of the window it publishes the edge count as a frequency reading for the top-level output pins. It provides single-shot measurement and, optionally, back-to-back continuous measurement.

## Interface
Parameters:
- `GATE_CYCLES`, 1000: gate window length in `clk` cycles; legal range 2..65535.
- `CNT_W`, 16: width of the edge counter and of `count_o`; legal range 4..24.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high; one clock domain only.
- `osc_in`  in  1  oscillator comparator output, asynchronous to `clk`.
- `start_i`  in  1  measurement request, level-sampled in IDLE.
- `count_o`  out  CNT_W  last latched edge count.
- `valid_o`  out  1  one-cycle pulse when `count_o` updates.
- `ovf_o`  out  1  the last measurement saturated; updates with `count_o`.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Input path:
  - `osc_in` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - `rise` = sync2 & ~sync3.
  - Synchronizer flops reset to 0, so a high `osc_in` at reset release produces one `rise` 3 cycles later.
- FSM states: IDLE, ARM, GATE, LATCH.
  - IDLE: `start_i`=1 -> ARM; otherwise stay.
  - ARM, one cycle: clear the edge counter to 0; load the gate counter with `GATE_CYCLES-1`; -> GATE.
  - GATE: each cycle with `rise`=1 increments the edge counter. The gate counter decrements every cycle. Gate counter == 0 -> LATCH. The cycle in which the gate counter is 0 still counts `rise`.
  - LATCH, one cycle: `count_o` <= edge counter; `ovf_o` <= saturation flag; `valid_o`=1. Then -> IDLE, or -> ARM when continuous mode is compiled in (see Configuration).
- Arithmetic:
  - The edge counter is CNT_W bits and saturates at 2^CNT_W-1; further edges are dropped.
  - The saturation flag sets the first time an increment is attempted at the all-ones value.
  - The saturation flag clears in ARM.
- `start_i` outside IDLE is ignored. No queuing.
- `count_o` and `ovf_o` hold between updates.
- Input constraint: `osc_in` high and low phases are each ≥ 2 `clk` periods. Violations may undercount; this is not flagged.

## Timing
- Reset values: `count_o`=0, `valid_o`=0, `ovf_o`=0, `busy_o`=0; FSM in IDLE; all counters and synchronizer flops 0.
- Reset asserted mid-measurement aborts immediately. No `valid_o` is produced, and outputs return to reset values.
- `start_i` is sampled at edge T:
  - ARM occupies T+1.
  - GATE occupies T+2 .. T+1+GATE_CYCLES.
  - LATCH, with `valid_o`=1, occupies T+2+GATE_CYCLES.
- Measurement latency from `start_i` to `valid_o` is GATE_CYCLES+2 cycles.
- `busy_o` is high from T+1 through the LATCH cycle inclusive in single-shot mode.
- An `osc_in` edge is counted if its `rise` pulse lands in GATE. `rise` lags the pin by 3 cycles.
- Throughput in continuous mode is one result per GATE_CYCLES+2 cycles.

## Configuration
- Macro: `RELAX_FREQ_CONT_EN`.
- Defined:
  - LATCH -> ARM unconditionally, so measurements repeat without further `start_i`.
  - `busy_o` stays high until reset.
- Undefined:
  - LATCH -> IDLE. Single-shot only; each measurement needs a new `start_i`.

## Test plan
- Reset check: assert `rst` asynchronously between clock edges. All outputs go to 0 without waiting for `clk`. `busy_o`=0 after release.
- Single shot, GATE_CYCLES=100: `osc_in` low; pulse `start_i` at T. Drive 7 rising edges spaced 8 cycles apart, the first at T+10. Required: `valid_o` pulse exactly at T+102, `count_o`=7, `ovf_o`=0, `busy_o` low at T+103.
- Saturation, CNT_W=4, GATE_CYCLES=200: drive 20 rising edges spaced 6 cycles apart inside the gate. Required: `count_o`=15, `ovf_o`=1. The next measurement with 3 edges gives `count_o`=3, `ovf_o`=0.
- Busy rejection: re-pulse `start_i` at T+50 during GATE. Required: exactly one `valid_o` pulse, at T+102, and no second measurement.
- Reset mid-GATE: assert `rst` at T+60. Required: no `valid_o` pulse, `count_o`=0. A new `start_i` after release measures normally.
- With `RELAX_FREQ_CONT_EN` defined, GATE_CYCLES=100, constant `osc_in` period 10 cycles, single `start_i`: `valid_o` pulses every 102 cycles, each `count_o` in {10, 11}, and `busy_o` stays high.
